// File: rtl/rd_resp_pkg.sv
// Shared constants and types for the SRAM read-response block: default widths,
// response FIFO depth and the burst-tracking state enum.
package rd_resp_pkg;

  localparam int DEF_AW     = 11;
  localparam int DEF_DW     = 64;
  localparam int FIFO_DEPTH = 3;
  localparam int CNT_W      = 2;  // holds 0..FIFO_DEPTH
  localparam int PTR_W      = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // Pointer increment with wrap at FIFO_DEPTH (depth is not a power of two).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) return '0;
    else                               return ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rd_resp_fifo.sv
// Three-entry first-in first-out buffer for response beats; exposes occupancy
// so the issue logic can reserve space for reads still in flight.
module rd_resp_fifo
  import rd_resp_pkg::*;
#(
  parameter int W = DEF_DW + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic [W-1:0]     store [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guards keep the pointers sane even if a caller misbehaves.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_rd_resp.sv
// SRAM read request/response bridge: issues reads on accepted requests, queues
// returned data with burst markers, and flags first/last protocol errors.
// Optional macro SRAM_RD_RESP_LAST_PULSE_EN enables the last_for_weight_ctrl pulse.
module sram_rd_resp
  import rd_resp_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] in_addr,
  input  logic          in_addr_first,
  input  logic          in_addr_last,
  input  logic          in_addr_valid,
  output logic          in_addr_ready,
  output logic          mem_cen,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_data_first,
  output logic          out_data_last,
  output logic          out_data_valid,
  input  logic          out_data_ready,
  output logic          last_for_weight_ctrl,
  output logic          err_proto
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both
  // high; valid never waits on ready, and ready never looks at the partner's valid.

  logic             accept;
  logic             pop;
  logic             inflight;
  logic             first_q;
  logic             last_q;
  logic [CNT_W-1:0] count;
  logic [2:0]       occupancy;
  logic [DW+1:0]    head;
  burst_state_t     state;
  burst_state_t     state_next;
  logic             err_set;

  // A read in flight already owns a FIFO slot, so credit counts it too.
  assign occupancy     = 3'(count) + 3'(inflight);
  assign in_addr_ready = (occupancy < 3'(FIFO_DEPTH));
  assign accept        = in_addr_valid && in_addr_ready && rst_n;

  assign mem_cen  = accept;
  assign mem_addr = in_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        first_q <= in_addr_first;
        last_q  <= in_addr_last;
      end
    end
  end

  rd_resp_fifo #(.W(DW + 2)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({first_q, last_q, mem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign out_data_valid = (count != '0);
  assign out_data_first = head[DW+1];
  assign out_data_last  = head[DW];
  assign out_data       = head[DW-1:0];
  assign pop            = out_data_valid && out_data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      err_proto <= 1'b0;
    end else begin
      state     <= state_next;
      err_proto <= err_proto | err_set;
    end
  end

  // A stray first inside a burst restarts it rather than being dropped.
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!in_addr_first)    err_set    = 1'b1;
          else if (!in_addr_last) state_next = BURST;
        end
        BURST: begin
          if (in_addr_first) err_set    = 1'b1;
          if (in_addr_last)  state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef SRAM_RD_RESP_LAST_PULSE_EN
  logic last_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_pulse <= 1'b0;
    else        last_pulse <= pop && out_data_last;
  end

  assign last_for_weight_ctrl = last_pulse;
`else
  assign last_for_weight_ctrl = 1'b0;
`endif

endmodule

// File: doc/sram_rd_resp.md
SRAM_RD_RESP -- requirements
Module: sram_rd_resp

Interface
REQ-001 Parameter AW, default 11, address width of the request stream.
REQ-002 Parameter DW, default 64, data width of the response stream and SRAM read port.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port in_addr / in_addr_first / in_addr_last  input  AW/1/1  request beat with burst markers.
REQ-006 Port in_addr_valid  input  1 / in_addr_ready  output  1  request handshake.
REQ-007 Port mem_cen  output  1  SRAM read enable, active-high.
REQ-008 Port mem_addr  output  AW  SRAM read address.
REQ-009 Port mem_rdata  input  DW  SRAM read data, valid exactly one cycle after mem_cen.
REQ-010 Port out_data / out_data_first / out_data_last  output  DW/1/1  response beat with markers.
REQ-011 Port out_data_valid  output  1 / out_data_ready  input  1  response handshake.
REQ-012 Port last_for_weight_ctrl  output  1  one-cycle pulse on acceptance of a last response beat.
REQ-013 Port err_proto  output  1  sticky burst-marker protocol error flag.

Function
REQ-014 Request accepted when in_addr_valid and in_addr_ready are both high; same cycle mem_cen=1 and mem_addr=in_addr; otherwise mem_cen=0.
REQ-015 in_addr_ready is high when fifo_count + inflight < 3; it does not depend combinationally on out_data_ready or in_addr_valid.
REQ-016 inflight register is set to 1 on the cycle after an accepted request, otherwise 0; when 1, mem_rdata with the registered first/last is pushed into the 3-entry response FIFO.
REQ-017 Response FIFO is first-in first-out; out_data_valid = (fifo_count != 0); out_data/first/last are the head entry.
REQ-018 Pop on out_data_valid and out_data_ready; simultaneous push and pop leaves count unchanged.
REQ-019 Latency: an accepted request with an empty FIFO presents out_data_valid two cycles later.
REQ-020 Throughput: one beat per cycle sustained while out_data_ready stays high; FIFO never overflows or underflows.
REQ-021 out_data holds stable while out_data_valid is high and out_data_ready is low.
REQ-022 Burst FSM has two states, IDLE and BURST, and advances on accepted requests only.
REQ-023 In IDLE: first=1 and last=1 stays in IDLE; first=1 and last=0 moves to BURST; first=0 sets err_proto and is still forwarded.
REQ-024 In BURST: last=1 moves to IDLE; first=1 sets err_proto and restarts the burst (BURST, or IDLE if last=1).
REQ-025 Requests are never dropped on error; first/last markers pass through unchanged.

Reset
REQ-026 While rst_n=0: FIFO count 0, inflight 0, FSM IDLE, err_proto 0, last_for_weight_ctrl 0, out_data_valid 0, in_addr_ready 1, mem_cen 0.
REQ-027 Reset mid-burst discards all inflight and queued beats; no response is produced after deassertion for requests accepted before reset.

Configuration
REQ-028 Macro SRAM_RD_RESP_LAST_PULSE_EN defined: last_for_weight_ctrl is a registered pulse, high the cycle after a beat with out_data_last=1 is accepted.
REQ-029 Macro undefined: last_for_weight_ctrl is tied to 0 and no logic is generated for it.

Structure
REQ-030 Shared package rd_resp_pkg holds default AW/DW, the FIFO depth constant (3) and the IDLE/BURST state enum.
REQ-031 The response FIFO is sub-module rd_resp_fifo (depth 3, width DW+2, count output); the FSM and issue logic stay in sram_rd_resp.

Verification
REQ-032 Single beat: addr 0x005 with first=1, last=1, mem returns 0xA5 -> out_data 0xA5, first=1, last=1, valid at cycle +2, last_for_weight_ctrl pulses once when the macro is defined.
REQ-033 Burst of 4 (0x010..0x013) with out_data_ready tied high -> 4 consecutive beats, first only on beat 0, last only on beat 3, err_proto stays 0.
REQ-034 Backpressure: out_data_ready low for 10 cycles during a burst of 8 -> in_addr_ready low after 3 queued or inflight beats, no loss or duplication, order preserved.
REQ-035 Protocol error: first=0 in IDLE, or first=1 in BURST -> err_proto rises the next cycle, stays high, and the beats still appear on out_data.
REQ-036 Reset asserted with 2 beats queued -> out_data_valid=0 and in_addr_ready=1 immediately; after release no stale beats are output.
